// File: rtl/usb_rx_packet_decompiler.sv
// RX packet decompiler: captures a flat received USB packet, checks its PID and size,
// then streams payload bytes 1..N-1 over a valid/ready byte interface.
module usb_rx_packet_decompiler #(
  parameter int unsigned MAX_BITS = 544,
  parameter int unsigned SIZE_W   = 10
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                i_packet_valid,
  input  logic [MAX_BITS-1:0] i_packet_rx,
  input  logic [SIZE_W-1:0]   i_packet_size_rx,
  input  logic                i_flush,
  input  logic                i_byte_ready,
  output logic                o_packet_ack,
  output logic [7:0]          o_byte_out,
  output logic                o_byte_valid,
  output logic                o_byte_last,
  output logic [3:0]          o_pid,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int unsigned IDX_W = 7;
  localparam int unsigned OFF_W = IDX_W + 3;
  localparam logic [SIZE_W-1:0] MaxSize = SIZE_W'(MAX_BITS);
  localparam logic [SIZE_W-1:0] MinSize = SIZE_W'(8);

  typedef enum logic [2:0] {StIdle, StCheck, StStream, StDone, StErr} state_t;

  state_t              r_state;
  logic [MAX_BITS-1:0] r_shadow;
  logic [SIZE_W-1:0]   r_size;
  logic [IDX_W-1:0]    r_index;
  logic [3:0]          r_pid;
  logic                r_busy;
  logic                r_byte_valid;
  logic                r_done;
  logic                r_err;

  logic [IDX_W-1:0]    w_n;
  logic [OFF_W-1:0]    w_bit_off;
  logic                w_size_bad;
  logic                w_pid_bad;
  logic                w_last;

  assign w_n        = r_size[IDX_W+2:3];
  assign w_bit_off  = {r_index, 3'b000};
  assign w_size_bad = (r_size[2:0] != 3'b000) || (r_size < MinSize) || (r_size > MaxSize);
  assign w_pid_bad  = (r_shadow[7:4] != ~r_shadow[3:0]);
  assign w_last     = (r_index == w_n - IDX_W'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= StIdle;
      r_shadow     <= '0;
      r_size       <= '0;
      r_index      <= '0;
      r_pid        <= '0;
      r_busy       <= 1'b0;
      r_byte_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (i_flush) begin
        // Abort silently: no done/err pulse for a flushed packet.
        r_state      <= StIdle;
        r_busy       <= 1'b0;
        r_byte_valid <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_packet_valid) begin
              r_shadow <= i_packet_rx;
              r_size   <= i_packet_size_rx;
              r_busy   <= 1'b1;
              r_state  <= StCheck;
            end
          end
          StCheck: begin
            if (w_size_bad || w_pid_bad) begin
              r_err   <= 1'b1;
              r_state <= StErr;
            end else begin
              r_pid   <= r_shadow[3:0];
              r_index <= IDX_W'(1);
              if (w_n == IDX_W'(1)) begin
                r_done  <= 1'b1;
                r_state <= StDone;
              end else begin
                r_byte_valid <= 1'b1;
                r_state      <= StStream;
              end
            end
          end
          StStream: begin
            if (i_byte_ready) begin
              if (w_last) begin
                r_byte_valid <= 1'b0;
                r_done       <= 1'b1;
                r_state      <= StDone;
              end else begin
                r_index <= r_index + IDX_W'(1);
              end
            end
          end
          StDone, StErr: begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
          default: begin
            r_busy       <= 1'b0;
            r_byte_valid <= 1'b0;
            r_state      <= StIdle;
          end
        endcase
      end
    end
  end

  // Ack is combinational so the producer sees it in the same cycle the packet is captured.
  assign o_packet_ack = (r_state == StIdle) && i_packet_valid && !i_flush;
  assign o_byte_out   = r_shadow[w_bit_off +: 8];
  assign o_byte_valid = r_byte_valid;
  assign o_byte_last  = r_byte_valid && w_last;
  assign o_pid        = r_pid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_usb_rx_packet_decompiler.sv
// Bench for usb_rx_packet_decompiler: directed and randomized packets checked against
// a byte-list / cycle-count reference model.
module tb_usb_rx_packet_decompiler;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         packet_valid;
  logic [543:0] packet_rx;
  logic [9:0]   packet_size_rx;
  logic         flush;
  logic         byte_ready;
  logic         packet_ack;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_last;
  logic [3:0]   pid;
  logic         busy;
  logic         done;
  logic         err;

  usb_rx_packet_decompiler dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .i_packet_valid   (packet_valid),
    .i_packet_rx      (packet_rx),
    .i_packet_size_rx (packet_size_rx),
    .i_flush          (flush),
    .i_byte_ready     (byte_ready),
    .o_packet_ack     (packet_ack),
    .o_byte_out       (byte_out),
    .o_byte_valid     (byte_valid),
    .o_byte_last      (byte_last),
    .o_pid            (pid),
    .o_busy           (busy),
    .o_done           (done),
    .o_err            (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_pid;
  bit ready_pat [400];

  // Observations of one packet transaction (relative cycle numbers, -1 = never seen)
  int ob_ack_t, ob_ack_cnt, ob_first_valid_t, ob_done_t, ob_done_cnt, ob_err_t, ob_err_cnt;
  int ob_hold_bad;
  bit ob_timeout, ob_pf_busy, ob_pf_valid;
  logic [7:0] ob_bytes [$];
  bit ob_lasts [$];

  function automatic bit pkt_ok(input logic [543:0] pkt, input logic [9:0] size);
    int s = int'(size);
    return (s % 8 == 0) && (s >= 8) && (s <= 544) && ((pkt[7:4] ^ pkt[3:0]) == 4'hF);
  endfunction

  // Cycle of the done pulse: bytes are offered from cycle 2, one leaves per ready cycle.
  function automatic int exp_done_t(input int nbytes);
    int t = 2;
    int sent = 0;
    while (sent < nbytes && t < 399) begin
      if (ready_pat[t]) sent++;
      t++;
    end
    return t;
  endfunction

  task automatic rand_packet(output logic [543:0] pkt, output logic [9:0] size, input bit allow_bad);
    logic [3:0] p;
    for (int w = 0; w < 17; w++) pkt[32*w +: 32] = $urandom;
    p = 4'($urandom_range(0, 15));
    pkt[7:0] = {~p, p};
    size = 10'(8 * $urandom_range(1, 68));
    if (allow_bad) begin
      case ($urandom_range(0, 7))
        0: pkt[7:4] = pkt[7:4] ^ 4'($urandom_range(1, 15));
        1: size = size | 10'($urandom_range(1, 7));
        2: size = 10'(8 * $urandom_range(69, 127));
        3: size = 10'($urandom_range(0, 7));
        default: ;
      endcase
    end
  endtask

  // Offers one packet and records what the DUT does; comparisons live in the tests.
  task automatic drive_packet(input logic [543:0] pkt, input logic [9:0] size, input int flush_cyc);
    bit acked = 0;
    bit finished = 0;
    bit holding = 0;
    int stop_t = -1;
    logic [7:0] held_b = 8'h00;
    logic held_l = 1'b0;
    ob_ack_t = -1; ob_ack_cnt = 0; ob_first_valid_t = -1; ob_done_t = -1; ob_done_cnt = 0;
    ob_err_t = -1; ob_err_cnt = 0; ob_hold_bad = 0; ob_timeout = 0; ob_pf_busy = 0;
    ob_pf_valid = 0;
    ob_bytes.delete();
    ob_lasts.delete();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      packet_valid   = !acked;
      packet_rx      = pkt;
      packet_size_rx = size;
      byte_ready     = ready_pat[t];
      flush          = (t == flush_cyc);
      #1;
      if (packet_ack) begin
        if (ob_ack_t < 0) ob_ack_t = t;
        ob_ack_cnt++;
        acked = 1;
      end
      if (byte_valid) begin
        if (ob_first_valid_t < 0) ob_first_valid_t = t;
        if (holding && (byte_out !== held_b || byte_last !== held_l)) ob_hold_bad++;
        if (byte_ready) begin
          ob_bytes.push_back(byte_out);
          ob_lasts.push_back(byte_last);
          holding = 0;
        end else begin
          holding = 1;
          held_b  = byte_out;
          held_l  = byte_last;
        end
      end else begin
        if (holding) ob_hold_bad++;
        holding = 0;
      end
      if (done) begin ob_done_cnt++; ob_done_t = t; end
      if (err) begin ob_err_cnt++; ob_err_t = t; end
      if (flush_cyc >= 0 && t == flush_cyc + 1) begin
        ob_pf_busy  = busy;
        ob_pf_valid = byte_valid;
      end
      if (stop_t < 0 && flush_cyc < 0 && (done || err)) stop_t = t + 1;
      if (stop_t < 0 && flush_cyc >= 0 && t == flush_cyc + 2) stop_t = t;
      if (stop_t >= 0 && t >= stop_t) begin
        finished = 1;
        break;
      end
    end
    ob_timeout   = !finished;
    packet_valid = 1'b0;
    flush        = 1'b0;
    byte_ready   = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; packet_valid = 1'b0; flush = 1'b0; byte_ready = 1'b0;
    packet_rx = '0; packet_size_rx = '0;
    @(negedge clk); #1;
    vectors++; if (byte_valid !== 1'b0) begin miscompares++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (pid !== 4'h0) begin miscompares++; $display("FAIL reset_pid got %h want 0", pid); end
    vectors++; if (packet_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", packet_ack); end
    @(negedge clk);
    n_rst = 1'b1;
    exp_pid = 4'h0;
  endtask

  task automatic test_data0();
    logic [543:0] pkt;
    logic [9:0] size;
    logic [7:0] exp_b [3];
    exp_b = '{8'h11, 8'h22, 8'h33};
    rand_packet(pkt, size, 0);
    pkt[31:0] = 32'h3322_11C3;
    for (int i = 0; i < 400; i++) ready_pat[i] = 1'b1;
    drive_packet(pkt, 10'd32, -1);
    exp_pid = 4'h3;
    vectors++; if (ob_timeout) begin miscompares++; $display("FAIL data0_timeout got 1 want 0"); end
    vectors++; if (ob_ack_t !== 0 || ob_ack_cnt !== 1) begin miscompares++; $display("FAIL data0_ack got t=%0d n=%0d want t=0 n=1", ob_ack_t, ob_ack_cnt); end
    vectors++; if (ob_first_valid_t !== 2) begin miscompares++; $display("FAIL data0_first_valid got %0d want 2", ob_first_valid_t); end
    vectors++; if (ob_bytes.size() !== 3) begin miscompares++; $display("FAIL data0_count got %0d want 3", ob_bytes.size()); end
    for (int j = 0; j < 3 && j < ob_bytes.size(); j++) begin
      vectors++; if (ob_bytes[j] !== exp_b[j] || ob_lasts[j] !== (j == 2)) begin
        miscompares++; $display("FAIL data0_byte%0d got %h/last%b want %h/last%b", j, ob_bytes[j], ob_lasts[j], exp_b[j], j == 2);
      end
    end
    vectors++; if (ob_done_t !== 5 || ob_done_cnt !== 1) begin miscompares++; $display("FAIL data0_done got t=%0d n=%0d want t=5 n=1", ob_done_t, ob_done_cnt); end
    vectors++; if (pid !== exp_pid) begin miscompares++; $display("FAIL data0_pid got %h want %h", pid, exp_pid); end
  endtask

  task automatic test_stall();
    logic [543:0] pkt;
    logic [9:0] size;
    logic [7:0] exp_b [3];
    exp_b = '{8'h11, 8'h22, 8'h33};
    rand_packet(pkt, size, 0);
    pkt[31:0] = 32'h3322_11C3;
    for (int i = 0; i < 400; i++) ready_pat[i] = (i >= 2) && ((i - 2) % 3 == 0);
    drive_packet(pkt, 10'd32, -1);
    vectors++; if (ob_bytes.size() !== 3) begin miscompares++; $display("FAIL stall_count got %0d want 3", ob_bytes.size()); end
    for (int j = 0; j < 3 && j < ob_bytes.size(); j++) begin
      vectors++; if (ob_bytes[j] !== exp_b[j] || ob_lasts[j] !== (j == 2)) begin
        miscompares++; $display("FAIL stall_byte%0d got %h/last%b want %h/last%b", j, ob_bytes[j], ob_lasts[j], exp_b[j], j == 2);
      end
    end
    vectors++; if (ob_hold_bad !== 0) begin miscompares++; $display("FAIL stall_hold got %0d unstable cycles want 0", ob_hold_bad); end
    vectors++; if (ob_done_t !== exp_done_t(3)) begin miscompares++; $display("FAIL stall_done got %0d want %0d", ob_done_t, exp_done_t(3)); end
  endtask

  task automatic test_handshake();
    logic [543:0] pkt;
    logic [9:0] size;
    rand_packet(pkt, size, 0);
    pkt[7:0] = 8'hD2;
    for (int i = 0; i < 400; i++) ready_pat[i] = 1'b1;
    drive_packet(pkt, 10'd8, -1);
    exp_pid = 4'h2;
    vectors++; if (ob_first_valid_t !== -1) begin miscompares++; $display("FAIL hs_no_bytes got first valid %0d want none", ob_first_valid_t); end
    vectors++; if (ob_done_t !== 2 || ob_done_cnt !== 1) begin miscompares++; $display("FAIL hs_done got t=%0d n=%0d want t=2 n=1", ob_done_t, ob_done_cnt); end
    vectors++; if (pid !== exp_pid) begin miscompares++; $display("FAIL hs_pid got %h want %h", pid, exp_pid); end
  endtask

  task automatic test_errors();
    logic [543:0] pkt;
    logic [9:0] size;
    logic [9:0] sizes [3];
    logic [7:0] b0s [3];
    sizes = '{10'd20, 10'd552, 10'd32};
    b0s   = '{8'hC3, 8'hC3, 8'hC4};
    for (int i = 0; i < 400; i++) ready_pat[i] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_packet(pkt, size, 0);
      pkt[7:0] = b0s[c];
      drive_packet(pkt, sizes[c], -1);
      vectors++; if (ob_err_t !== 2 || ob_err_cnt !== 1) begin miscompares++; $display("FAIL err%0d_pulse got t=%0d n=%0d want t=2 n=1", c, ob_err_t, ob_err_cnt); end
      vectors++; if (ob_first_valid_t !== -1 || ob_done_cnt !== 0) begin miscompares++; $display("FAIL err%0d_quiet got valid@%0d done=%0d want none", c, ob_first_valid_t, ob_done_cnt); end
      vectors++; if (pid !== exp_pid) begin miscompares++; $display("FAIL err%0d_pid got %h want %h", c, pid, exp_pid); end
    end
  endtask

  task automatic test_flush();
    logic [543:0] pkt;
    logic [9:0] size;
    int n;
    rand_packet(pkt, size, 0);
    for (int i = 0; i < 400; i++) ready_pat[i] = (i != 3);
    drive_packet(pkt, 10'd544, 3);
    exp_pid = pkt[3:0];
    vectors++; if (ob_bytes.size() !== 1) begin miscompares++; $display("FAIL flush_count got %0d want 1", ob_bytes.size()); end
    else begin
      vectors++; if (ob_bytes[0] !== pkt[15:8]) begin miscompares++; $display("FAIL flush_byte1 got %h want %h", ob_bytes[0], pkt[15:8]); end
    end
    vectors++; if (ob_pf_valid !== 0 || ob_pf_busy !== 0) begin miscompares++; $display("FAIL flush_idle got valid=%b busy=%b want 0/0", ob_pf_valid, ob_pf_busy); end
    vectors++; if (ob_done_cnt !== 0 || ob_err_cnt !== 0) begin miscompares++; $display("FAIL flush_pulses got done=%0d err=%0d want 0/0", ob_done_cnt, ob_err_cnt); end
    // The next packet must start fresh from its own byte 1.
    rand_packet(pkt, size, 0);
    for (int i = 0; i < 400; i++) ready_pat[i] = 1'b1;
    drive_packet(pkt, size, -1);
    n = int'(size) / 8;
    exp_pid = pkt[3:0];
    vectors++; if (ob_ack_t !== 0) begin miscompares++; $display("FAIL flush_next_ack got %0d want 0", ob_ack_t); end
    vectors++; if (ob_bytes.size() !== n - 1) begin miscompares++; $display("FAIL flush_next_count got %0d want %0d", ob_bytes.size(), n - 1); end
    for (int j = 0; j < n - 1 && j < ob_bytes.size(); j++) begin
      vectors++; if (ob_bytes[j] !== pkt[8*(j+1) +: 8]) begin miscompares++; $display("FAIL flush_next_byte%0d got %h want %h", j + 1, ob_bytes[j], pkt[8*(j+1) +: 8]); end
    end
    vectors++; if (ob_done_t !== exp_done_t(n - 1)) begin miscompares++; $display("FAIL flush_next_done got %0d want %0d", ob_done_t, exp_done_t(n - 1)); end
  endtask

  task automatic test_reset_midstream();
    logic [543:0] pkt;
    logic [9:0] size;
    bit acked = 0;
    int seen = 0;
    rand_packet(pkt, size, 0);
    for (int t = 0; t < 20 && seen < 3; t++) begin
      @(negedge clk);
      packet_valid = !acked; packet_rx = pkt; packet_size_rx = 10'd544; byte_ready = 1'b1;
      #1;
      if (packet_ack) acked = 1;
      if (byte_valid) seen++;
    end
    vectors++; if (seen !== 3) begin miscompares++; $display("FAIL rstmid_stream got %0d bytes want 3", seen); end
    @(negedge clk);
    packet_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    vectors++; if (byte_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle got valid=%b busy=%b want 0/0", byte_valid, busy); end
    vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL rstmid_pulses got done=%b err=%b want 0/0", done, err); end
    vectors++; if (pid !== 4'h0) begin miscompares++; $display("FAIL rstmid_pid got %h want 0", pid); end
    @(negedge clk);
    n_rst = 1'b1;
    byte_ready = 1'b0;
    exp_pid = 4'h0;
  endtask

  task automatic test_back_to_back();
    logic [543:0] pkt;
    logic [9:0] size;
    int n;
    for (int p = 0; p < 25; p++) begin
      rand_packet(pkt, size, 1);
      for (int i = 0; i < 400; i++) ready_pat[i] = ($urandom_range(0, 3) != 0);
      drive_packet(pkt, size, -1);
      vectors++; if (ob_timeout || ob_ack_t !== 0) begin miscompares++; $display("FAIL b2b%0d_ack got t=%0d timeout=%b want t=0", p, ob_ack_t, ob_timeout); end
      if (pkt_ok(pkt, size)) begin
        n = int'(size) / 8;
        exp_pid = pkt[3:0];
        vectors++; if (ob_bytes.size() !== n - 1 || ob_err_cnt !== 0) begin miscompares++; $display("FAIL b2b%0d_count got %0d err=%0d want %0d err=0", p, ob_bytes.size(), ob_err_cnt, n - 1); end
        for (int j = 0; j < n - 1 && j < ob_bytes.size(); j++) begin
          vectors++; if (ob_bytes[j] !== pkt[8*(j+1) +: 8] || ob_lasts[j] !== (j == n - 2)) begin
            miscompares++; $display("FAIL b2b%0d_byte%0d got %h/last%b want %h/last%b", p, j + 1, ob_bytes[j], ob_lasts[j], pkt[8*(j+1) +: 8], j == n - 2);
          end
        end
        vectors++; if (ob_done_t !== exp_done_t(n - 1) || ob_done_cnt !== 1) begin miscompares++; $display("FAIL b2b%0d_done got t=%0d n=%0d want t=%0d n=1", p, ob_done_t, ob_done_cnt, exp_done_t(n - 1)); end
        vectors++; if (ob_hold_bad !== 0) begin miscompares++; $display("FAIL b2b%0d_hold got %0d want 0", p, ob_hold_bad); end
      end else begin
        vectors++; if (ob_err_t !== 2 || ob_bytes.size() !== 0 || ob_done_cnt !== 0) begin miscompares++; $display("FAIL b2b%0d_err got err@%0d bytes=%0d done=%0d want err@2 0 0", p, ob_err_t, ob_bytes.size(), ob_done_cnt); end
      end
      vectors++; if (pid !== exp_pid) begin miscompares++; $display("FAIL b2b%0d_pid got %h want %h", p, pid, exp_pid); end
    end
  endtask

  initial begin
    test_reset();
    test_data0();
    test_stall();
    test_handshake();
    test_errors();
    test_flush();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
